mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
- Consumer of the hole-index stream from the game's random index generator (values 1..30, one per clock).
- Each round it waits a gap, samples an index, raises a single mole at that hole for a bounded lifetime, and resolves hammer hits or timeouts.
- Tracks score and misses, and asserts game over after a set number of misses.
- Sits between the random generator and the display/input logic of the whack-a-mole top level.

Parameters:
IDX_W, 5, width of hole index
MIN_IDX, 1, lowest valid hole index
MAX_IDX, 30, highest valid hole index
GAP_CYCLES, 50000000, clocks between mole retract and next spawn attempt (>=1)
LIFE_CYCLES, 100000000, clocks a mole stays up (>=1)
MAX_MISS, 3, misses that end the game (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level/pulse; starts a new game from IDLE or OVER
rand_idx  in  IDX_W  candidate hole index from random generator
hit_valid  in  1  one-cycle strobe: player struck a hole
hit_idx  in  IDX_W  hole struck, qualified by hit_valid
mole_up  out  1  a mole is currently visible
mole_idx  out  IDX_W  hole of visible or last mole
score  out  8  successful hits, saturating
misses  out  4  timed-out moles this game
hit_pulse  out  1  one-cycle pulse on a successful hit
miss_pulse  out  1  one-cycle pulse on a mole timeout
game_over  out  1  high in OVER state

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mole_up=0, mole_idx=0, score=0, misses=0, hit_pulse=0, miss_pulse=0, game_over=0, gap_cnt=0, life_cnt=0, last_idx=0. Outputs are registered.
- States: IDLE, GAP, UP, OVER.
- IDLE: start=1 at an edge -> GAP, gap_cnt<=GAP_CYCLES-1; score, misses and last_idx are cleared.
- GAP: while gap_cnt>0, decrement. At an edge with gap_cnt==0:
  - If MIN_IDX<=rand_idx<=MAX_IDX and rand_idx!=last_idx: spawn -> UP, mole_idx<=rand_idx, last_idx<=rand_idx, mole_up<=1, life_cnt<=LIFE_CYCLES-1.
  - Else: stay in GAP with gap_cnt at 0 and retry next cycle. Index 0, 31 and immediate repeats are rejected.
- Timing: mole_up rises exactly GAP_CYCLES edges after the edge that sampled start (or after retract), plus one per rejected sample.
- UP, evaluated at each edge, priority order:
  1. hit_valid=1 and hit_idx==mole_idx: mole_up<=0, score<=score+1 (holds at 255), hit_pulse<=1, -> GAP with gap_cnt<=GAP_CYCLES-1.
  2. life_cnt==0: mole_up<=0, misses<=misses+1, miss_pulse<=1. If misses+1==MAX_MISS -> OVER, else -> GAP with gap_cnt reloaded.
  3. Otherwise life_cnt decrements.
  - A hit on the wrong hole is ignored: no penalty and no state change.
  - A correct hit on the same edge as life_cnt==0 counts as a hit, not a miss.
  - The mole is visible for exactly LIFE_CYCLES cycles if not hit.
- OVER: game_over=1, mole_up=0; score and misses hold. start=1 -> GAP as from IDLE (counters cleared, game_over<=0 on the same edge).
- start in GAP or UP is ignored.
- hit_valid outside UP is ignored.
- hit_pulse and miss_pulse are high for exactly one cycle and never high together.
- mole_idx holds its last value after retract.
- Reset asserted mid-game returns immediately to the reset values. There is no auto-restart; a new start is required.

Test Plan:
(Parameters for all scenarios: GAP_CYCLES=4, LIFE_CYCLES=6, MAX_MISS=3.)
- Reset, then start pulse at edge 0 with rand_idx=7 -> mole_up=1 after edge 4, mole_idx=7, score=0.
- Mole up at 7; hit_valid with hit_idx=7 on 3rd up cycle -> mole_up=0 next edge, hit_pulse for 1 cycle, score=1, next spawn 4 edges later.
- Mole up at 7, no hits -> mole_up high for exactly 6 cycles, then miss_pulse, misses=1. After 3 such misses -> game_over=1, mole_up stays 0, start restarts with score=0, misses=0.
- At spawn time, rand_idx sequence 0, 31, 7 (last_idx=7), 12 -> spawn delayed 3 cycles, mole_idx=12.
- Wrong hit (hit_idx=5 on mole 12), then a correct hit on the same edge as life_cnt==0 -> wrong hit ignored, final outcome hit (score+1, misses unchanged).
- score forced to 255 via repeated hits -> stays 255. rst_n low mid-UP -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/mole_scheduler.sv
// Whack-a-mole round scheduler: waits a gap, picks a hole from the random
// index stream, shows one mole for a bounded lifetime and resolves it as a
// hit or a miss. Keeps score and misses and ends the game after MAX_MISS
// misses.
module mole_scheduler #(
    parameter int IDX_W       = 5,
    parameter int MIN_IDX     = 1,
    parameter int MAX_IDX     = 30,
    parameter int GAP_CYCLES  = 50000000,
    parameter int LIFE_CYCLES = 100000000,
    parameter int MAX_MISS    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] rand_idx,
    input  logic             hit_valid,
    input  logic [IDX_W-1:0] hit_idx,
    output logic             mole_up,
    output logic [IDX_W-1:0] mole_idx,
    output logic [7:0]       score,
    output logic [3:0]       misses,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic             game_over
);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        UP,
        OVER
    } state_t;

    // Counters are 32 bits so the default second-scale timings fit.
    localparam logic [31:0]      GAP_LOAD  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]      LIFE_LOAD = 32'(LIFE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LO    = IDX_W'(MIN_IDX);
    localparam logic [IDX_W-1:0] IDX_HI    = IDX_W'(MAX_IDX);
    localparam logic [3:0]       MISS_LIM  = 4'(MAX_MISS);

    state_t           state, state_n;
    logic [31:0]      gap_cnt, gap_cnt_n;
    logic [31:0]      life_cnt, life_cnt_n;
    logic [IDX_W-1:0] last_idx, last_idx_n;
    logic             mole_up_n;
    logic [IDX_W-1:0] mole_idx_n;
    logic [7:0]       score_n;
    logic [3:0]       misses_n;
    logic             hit_pulse_n;
    logic             miss_pulse_n;
    logic             game_over_n;

    logic             idx_ok;
    logic             good_hit;
    logic [3:0]       misses_inc;

    assign idx_ok     = (rand_idx >= IDX_LO) && (rand_idx <= IDX_HI) && (rand_idx != last_idx);
    assign good_hit   = hit_valid && (hit_idx == mole_idx);
    assign misses_inc = misses + 4'd1;

    // Register the state, counters and all outputs; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            life_cnt   <= '0;
            last_idx   <= '0;
            mole_up    <= 1'b0;
            mole_idx   <= '0;
            score      <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            gap_cnt    <= gap_cnt_n;
            life_cnt   <= life_cnt_n;
            last_idx   <= last_idx_n;
            mole_up    <= mole_up_n;
            mole_idx   <= mole_idx_n;
            score      <= score_n;
            misses     <= misses_n;
            hit_pulse  <= hit_pulse_n;
            miss_pulse <= miss_pulse_n;
            game_over  <= game_over_n;
        end
    end

    // Next-state and next-output logic; a hit beats a timeout on the same edge.
    always_comb begin
        state_n      = state;
        gap_cnt_n    = gap_cnt;
        life_cnt_n   = life_cnt;
        last_idx_n   = last_idx;
        mole_up_n    = mole_up;
        mole_idx_n   = mole_idx;
        score_n      = score;
        misses_n     = misses;
        hit_pulse_n  = 1'b0;
        miss_pulse_n = 1'b0;

        case (state)
            IDLE, OVER: begin
                mole_up_n = 1'b0;
                if (start) begin
                    state_n    = GAP;
                    gap_cnt_n  = GAP_LOAD;
                    score_n    = '0;
                    misses_n   = '0;
                    last_idx_n = '0;
                end
            end
            GAP: begin
                if (gap_cnt != 32'd0) begin
                    gap_cnt_n = gap_cnt - 32'd1;
                end else if (idx_ok) begin
                    state_n    = UP;
                    mole_idx_n = rand_idx;
                    last_idx_n = rand_idx;
                    mole_up_n  = 1'b1;
                    life_cnt_n = LIFE_LOAD;
                end
            end
            UP: begin
                if (good_hit) begin
                    mole_up_n   = 1'b0;
                    hit_pulse_n = 1'b1;
                    if (score != 8'hFF) begin
                        score_n = score + 8'd1;
                    end
                    state_n   = GAP;
                    gap_cnt_n = GAP_LOAD;
                end else if (life_cnt == 32'd0) begin
                    mole_up_n    = 1'b0;
                    miss_pulse_n = 1'b1;
                    misses_n     = misses_inc;
                    if (misses_inc == MISS_LIM) begin
                        state_n = OVER;
                    end else begin
                        state_n   = GAP;
                        gap_cnt_n = GAP_LOAD;
                    end
                end else begin
                    life_cnt_n = life_cnt - 32'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        game_over_n = (state_n == OVER);
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed testbench for mole_scheduler with short gap/life timings.
module tb_mole_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] randIdx;
    logic       hitValid;
    logic [4:0] hitIdx;
    logic       moleUp;
    logic [4:0] moleIdx;
    logic [7:0] score;
    logic [3:0] misses;
    logic       hitPulse;
    logic       missPulse;
    logic       gameOver;

    int compareCount;
    int mismatchCount;

    mole_scheduler #(
        .IDX_W(5), .MIN_IDX(1), .MAX_IDX(30),
        .GAP_CYCLES(4), .LIFE_CYCLES(6), .MAX_MISS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rand_idx(randIdx),
        .hit_valid(hitValid), .hit_idx(hitIdx), .mole_up(moleUp),
        .mole_idx(moleIdx), .score(score), .misses(misses),
        .hit_pulse(hitPulse), .miss_pulse(missPulse), .game_over(gameOver)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until the mole rises, then check the delay and the chosen hole.
    task automatic waitSpawn(input int expTicks, input logic [4:0] expIdx);
        int n;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (moleUp) break;
        end
        checkOutput("spawnDelay", n, expTicks);
        checkOutput("spawnIdx", 32'(moleIdx), 32'(expIdx));
    endtask

    // Let a raised mole time out and check its visible length and the miss.
    task automatic runMiss(input int expMisses);
        int n;
        n = 1;
        while (n < 40) begin
            tick();
            if (!moleUp) break;
            n++;
        end
        checkOutput("upCycles", n, 6);
        checkOutput("missPulse", 32'(missPulse), 1);
        checkOutput("hitPulseOnMiss", 32'(hitPulse), 0);
        checkOutput("missCount", 32'(misses), 32'(expMisses));
    endtask

    // Hit the currently visible mole on the next edge.
    task automatic applyStimulus(input logic [4:0] idx);
        hitValid = 1'b1;
        hitIdx   = idx;
        tick();
        hitValid = 1'b0;
        hitIdx   = 5'd0;
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        randIdx  = 5'd7;
        hitValid = 1'b0;
        hitIdx   = 5'd0;

        tick();
        tick();
        checkOutput("rstMoleUp", 32'(moleUp), 0);
        checkOutput("rstScore", 32'(score), 0);
        checkOutput("rstGameOver", 32'(gameOver), 0);
        rst_n = 1'b1;
        tick();
        checkOutput("idleMoleUp", 32'(moleUp), 0);

        // First spawn four edges after the start edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        waitSpawn(4, 5'd7);
        checkOutput("firstScore", 32'(score), 0);

        // Hit on the third up cycle.
        tick();
        tick();
        randIdx = 5'd9;
        applyStimulus(5'd7);
        checkOutput("hitMoleUp", 32'(moleUp), 0);
        checkOutput("hitPulse", 32'(hitPulse), 1);
        checkOutput("hitScore", 32'(score), 1);
        waitSpawn(4, 5'd9);

        // Three timeouts end the game.
        runMiss(1);
        randIdx = 5'd10;
        waitSpawn(4, 5'd10);
        runMiss(2);
        randIdx = 5'd11;
        waitSpawn(4, 5'd11);
        runMiss(3);
        checkOutput("overFlag", 32'(gameOver), 1);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("overMoleUp", 32'(moleUp), 0);
        checkOutput("overGameOver", 32'(gameOver), 1);
        checkOutput("overScoreHeld", 32'(score), 1);
        checkOutput("overMissHeld", 32'(misses), 3);

        // Restart clears score and misses.
        randIdx = 5'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restartGameOver", 32'(gameOver), 0);
        checkOutput("restartScore", 32'(score), 0);
        checkOutput("restartMisses", 32'(misses), 0);
        waitSpawn(4, 5'd7);

        // Rejected samples 0, 31 and a repeat of 7 delay the spawn by 3.
        applyStimulus(5'd7);
        checkOutput("hitScore2", 32'(score), 1);
        tick();
        tick();
        tick();
        randIdx = 5'd0;
        tick();
        checkOutput("reject0", 32'(moleUp), 0);
        randIdx = 5'd31;
        tick();
        checkOutput("reject31", 32'(moleUp), 0);
        randIdx = 5'd7;
        tick();
        checkOutput("rejectRepeat", 32'(moleUp), 0);
        randIdx = 5'd12;
        tick();
        checkOutput("delayedSpawn", 32'(moleUp), 1);
        checkOutput("delayedIdx", 32'(moleIdx), 12);

        // Wrong hit ignored; correct hit on the timeout edge counts as a hit.
        tick();
        applyStimulus(5'd5);
        checkOutput("wrongHitUp", 32'(moleUp), 1);
        checkOutput("wrongHitPulse", 32'(hitPulse), 0);
        checkOutput("wrongHitScore", 32'(score), 1);
        tick();
        tick();
        tick();
        applyStimulus(5'd12);
        checkOutput("lastEdgeUp", 32'(moleUp), 0);
        checkOutput("lastEdgeHit", 32'(hitPulse), 1);
        checkOutput("lastEdgeMiss", 32'(missPulse), 0);
        checkOutput("lastEdgeScore", 32'(score), 2);
        checkOutput("lastEdgeMisses", 32'(misses), 0);
        tick();
        checkOutput("hitPulseOneCycle", 32'(hitPulse), 0);

        // Saturate the score with repeated hits.
        for (int k = 0; k < 254; k++) begin
            randIdx = (k % 2 == 0) ? 5'd3 : 5'd4;
            waitSpawn((k == 0) ? 3 : 4, randIdx);
            applyStimulus(randIdx);
        end
        checkOutput("scoreSaturated", 32'(score), 255);
        checkOutput("satHitPulse", 32'(hitPulse), 1);

        // Asynchronous reset in the middle of an up phase.
        randIdx = 5'd20;
        waitSpawn(4, 5'd20);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstMoleUp", 32'(moleUp), 0);
        checkOutput("asyncRstIdx", 32'(moleIdx), 0);
        checkOutput("asyncRstScore", 32'(score), 0);
        checkOutput("asyncRstMisses", 32'(misses), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checkOutput("noAutoRestart", 32'(moleUp), 0);
        checkOutput("noAutoOver", 32'(gameOver), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
